// File: rtl/ram_memory_strb.sv
// ram_memory_strb -- word-addressed synchronous data RAM with byte strobes.
//
// Purpose:
//   General-purpose data memory on the core bus, decoded at ADDR_BASE and
//   MEM_SIZE words deep. Each byte lane keeps its own storage array, so a
//   strobed write is a plain per-lane write enable. After reset release the
//   contents are zeroed one word per cycle, and requests are accepted only
//   once that sweep has finished (ready high).
//
// Ports:
//   clk          rising-edge clock
//   nreset       asynchronous active-low reset
//   write_en     write request
//   write_strb   byte-lane enables for the write (bit i -> data_write[8i+:8])
//   addr_write   absolute word address of the write
//   data_write   write data
//   read_en      read request
//   addr_read    absolute word address of the read
//   data_read    registered read data (holds between reads)
//   read_valid   one-cycle pulse: data_read was updated
//   ready        high once the clear sweep is done
//   error        one-cycle pulse after an out-of-range request

// One byte lane of the array: a single write port and an async read port.
// The storage is deliberately not reset; the top-level sweep clears it.
module ram_memory_strb_lane #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [7:0]       wbyte_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [7:0]       rbyte_o
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[widx_i] <= wbyte_i;
  end

  assign rbyte_o = mem[ridx_i];
endmodule

module ram_memory_strb #(
  parameter int unsigned BUS_WIDTH   = 32,
  parameter int unsigned ADDR_BASE   = 0,
  parameter int unsigned MEM_SIZE    = 256,
  parameter bit          READ_BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   write_en,
  input  logic [BUS_WIDTH/8-1:0] write_strb,
  input  logic [BUS_WIDTH-1:0]   addr_write,
  input  logic [BUS_WIDTH-1:0]   data_write,
  input  logic                   read_en,
  input  logic [BUS_WIDTH-1:0]   addr_read,
  output logic [BUS_WIDTH-1:0]   data_read,
  output logic                   read_valid,
  output logic                   ready,
  output logic                   error
);
  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int IDX_W      = $clog2(MEM_SIZE);
  // Range compare is done one bit wider than both operands so MEM_SIZE can
  // never be truncated against a narrow bus.
  localparam int CMP_W      = (BUS_WIDTH > 32) ? BUS_WIDTH + 1 : 33;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_SIZE - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       clear_idx_q, clear_idx_d;
  logic                   ready_q, ready_d;
  logic [BUS_WIDTH-1:0]   data_read_q, data_read_d;
  logic                   read_valid_q, read_valid_d;
  logic                   error_q, error_d;

  // Address decode: subtraction wraps addresses below the base to huge
  // values, which the single unsigned compare then rejects.
  logic [BUS_WIDTH-1:0]   w_idx, r_idx;
  logic                   w_in, r_in, same_idx;

  assign w_idx    = addr_write - BUS_WIDTH'(ADDR_BASE);
  assign r_idx    = addr_read  - BUS_WIDTH'(ADDR_BASE);
  assign w_in     = CMP_W'(w_idx) < CMP_W'(MEM_SIZE);
  assign r_in     = CMP_W'(r_idx) < CMP_W'(MEM_SIZE);
  assign same_idx = write_en && w_in && r_in && (w_idx == r_idx);

  // Lane-array write port, shared between the clear sweep and bus writes.
  logic [STRB_WIDTH-1:0]      lane_we;
  logic [IDX_W-1:0]           lane_widx;
  logic [STRB_WIDTH-1:0][7:0] lane_wdata;
  logic [STRB_WIDTH-1:0][7:0] lane_rdata;
  logic [STRB_WIDTH-1:0][7:0] rd_word;
  logic [STRB_WIDTH-1:0][7:0] wr_bytes;

  assign wr_bytes = data_write;

  for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_lane
    ram_memory_strb_lane #(
      .DEPTH (MEM_SIZE),
      .IDX_W (IDX_W)
    ) u_lane (
      .clk     (clk),
      .we_i    (lane_we[i]),
      .widx_i  (lane_widx),
      .wbyte_i (lane_wdata[i]),
      .ridx_i  (r_idx[IDX_W-1:0]),
      .rbyte_o (lane_rdata[i])
    );

    // Forward only the lanes actually being written this cycle; the rest
    // come from the array, which is exactly what it will hold afterwards.
    assign rd_word[i] = (READ_BYPASS && same_idx && write_strb[i])
                        ? wr_bytes[i] : lane_rdata[i];
  end

  always_comb begin
    state_d      = state_q;
    clear_idx_d  = clear_idx_q;
    ready_d      = ready_q;
    data_read_d  = data_read_q;
    read_valid_d = 1'b0;
    error_d      = 1'b0;
    lane_we      = '0;
    lane_widx    = w_idx[IDX_W-1:0];
    lane_wdata   = wr_bytes;

    unique case (state_q)
      CLEAR: begin
        // Bus requests are ignored; zero one word per cycle.
        lane_we     = '1;
        lane_widx   = clear_idx_q;
        lane_wdata  = '0;
        clear_idx_d = clear_idx_q + IDX_W'(1);
        if (clear_idx_q == LAST_IDX) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (write_en && w_in) lane_we = write_strb;
        read_valid_d = read_en;
        // One flag for both ports: a combined bad read+write is one pulse.
        error_d      = (write_en && !w_in) || (read_en && !r_in);
        if (read_en) data_read_d = r_in ? BUS_WIDTH'(rd_word) : '0;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= CLEAR;
      clear_idx_q  <= '0;
      ready_q      <= 1'b0;
      data_read_q  <= '0;
      read_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_idx_q  <= clear_idx_d;
      ready_q      <= ready_d;
      data_read_q  <= data_read_d;
      read_valid_q <= read_valid_d;
      error_q      <= error_d;
    end
  end

  assign data_read  = data_read_q;
  assign read_valid = read_valid_q;
  assign ready      = ready_q;
  assign error      = error_q;
endmodule

// File: tb/tb_ram_memory_strb.sv
// Testbench for ram_memory_strb: two instances (forwarding on / off) share
// all stimulus and are compared against a word-array reference model.
module tb_ram_memory_strb;
  localparam int          BW   = 32;
  localparam int          SW   = BW / 8;
  localparam int          MS   = 256;
  localparam logic [31:0] BASE = 32'h100;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          write_en = 1'b0, read_en = 1'b0;
  logic [SW-1:0] write_strb = '0;
  logic [BW-1:0] addr_write = '0, data_write = '0, addr_read = '0;
  logic [BW-1:0] dr0, dr1;
  logic          rv0, rv1, rdy0, rdy1, err0, err1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ram_memory_strb #(.BUS_WIDTH(BW), .ADDR_BASE(BASE), .MEM_SIZE(MS), .READ_BYPASS(1'b1)) dut0 (
    .clk(clk), .nreset(nreset), .write_en(write_en), .write_strb(write_strb),
    .addr_write(addr_write), .data_write(data_write), .read_en(read_en),
    .addr_read(addr_read), .data_read(dr0), .read_valid(rv0), .ready(rdy0), .error(err0));

  ram_memory_strb #(.BUS_WIDTH(BW), .ADDR_BASE(BASE), .MEM_SIZE(MS), .READ_BYPASS(1'b0)) dut1 (
    .clk(clk), .nreset(nreset), .write_en(write_en), .write_strb(write_strb),
    .addr_write(addr_write), .data_write(data_write), .read_en(read_en),
    .addr_read(addr_read), .data_read(dr1), .read_valid(rv1), .ready(rdy1), .error(err1));

  // Reference model: contents as a word array, clear counted in cycles.
  logic [BW-1:0] mem_m [MS];
  int            clr_left = MS;
  logic [BW-1:0] e_dr0 = '0, e_dr1 = '0;
  logic          e_rv = 1'b0, e_err = 1'b0, e_rdy = 1'b0;

  task automatic model_reset();
    clr_left = MS;
    e_dr0 = '0; e_dr1 = '0; e_rv = 1'b0; e_err = 1'b0; e_rdy = 1'b0;
  endtask

  // Drive one cycle of requests, predict the outputs after the next edge,
  // then advance to 1 time unit past that edge.
  task automatic step(input logic we, input logic [SW-1:0] st, input logic [31:0] wa,
                      input logic [31:0] wd, input logic re, input logic [31:0] ra);
    logic [31:0] wi, ri, merged;
    bit win, rin;
    write_en = we; write_strb = st; addr_write = wa; data_write = wd;
    read_en = re; addr_read = ra;
    wi = wa - BASE; ri = ra - BASE;
    win = (wi < MS); rin = (ri < MS);
    e_rv = 1'b0; e_err = 1'b0;
    if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) foreach (mem_m[k]) mem_m[k] = '0;
    end else begin
      e_rv  = re;
      e_err = (we && !win) || (re && !rin);
      if (re) begin
        if (rin) begin
          merged = mem_m[ri];
          if (we && win && wi == ri)
            for (int b = 0; b < SW; b++) if (st[b]) merged[8*b +: 8] = wd[8*b +: 8];
          e_dr0 = merged;
          e_dr1 = mem_m[ri];
        end else begin
          e_dr0 = '0; e_dr1 = '0;
        end
      end
      if (we && win)
        for (int b = 0; b < SW; b++) if (st[b]) mem_m[wi][8*b +: 8] = wd[8*b +: 8];
    end
    e_rdy = (clr_left == 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (dr0 !== '0) $display("FAIL reset_dr got %h exp 0", dr0); else n_pass++;
    n_chk++; if (rv0 !== 1'b0 || rv1 !== 1'b0) $display("FAIL reset_rv got %b%b exp 00", rv0, rv1); else n_pass++;
    n_chk++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) $display("FAIL reset_rdy got %b%b exp 00", rdy0, rdy1); else n_pass++;
    n_chk++; if (err0 !== 1'b0) $display("FAIL reset_err got %b exp 0", err0); else n_pass++;
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    // Reads held throughout the clear must be ignored.
    for (int c = 1; c <= MS; c++) begin
      step(1'b0, '0, '0, '0, 1'b1, BASE);
      n_chk++; if (rdy0 !== e_rdy || rdy1 !== e_rdy)
        $display("FAIL clear_ready cyc %0d got %b%b exp %b", c, rdy0, rdy1, e_rdy); else n_pass++;
      n_chk++; if (rv0 !== 1'b0 || err0 !== 1'b0)
        $display("FAIL clear_rv_err cyc %0d got rv %b err %b exp 0 0", c, rv0, err0); else n_pass++;
    end
    n_chk++; if (rdy0 !== 1'b1) $display("FAIL ready_after_clear got %b exp 1", rdy0); else n_pass++;
    step(1'b0, '0, '0, '0, 1'b1, BASE);
    n_chk++; if (rv0 !== 1'b1 || dr0 !== 32'h0 || dr1 !== 32'h0)
      $display("FAIL first_read got rv %b dr %h/%h exp 1 0/0", rv0, dr0, dr1); else n_pass++;
  endtask

  task automatic test_strobe();
    step(1'b1, 4'hF, BASE + 5, 32'hAABBCCDD, 1'b0, '0);
    step(1'b1, 4'h5, BASE + 5, 32'h11223344, 1'b0, '0);
    n_chk++; if (rv0 !== 1'b0) $display("FAIL strobe_no_rv got %b exp 0", rv0); else n_pass++;
    step(1'b0, '0, '0, '0, 1'b1, BASE + 5);
    n_chk++; if (dr0 !== 32'hAA22CC44 || dr1 !== 32'hAA22CC44)
      $display("FAIL strobe_merge got %h/%h exp aa22cc44", dr0, dr1); else n_pass++;
    n_chk++; if (rv0 !== 1'b1) $display("FAIL strobe_rv got %b exp 1", rv0); else n_pass++;
    idle();
    n_chk++; if (rv0 !== 1'b0 || dr0 !== 32'hAA22CC44)
      $display("FAIL strobe_hold got rv %b dr %h exp 0 aa22cc44", rv0, dr0); else n_pass++;
    // Empty strobe: no change, no error.
    step(1'b1, 4'h0, BASE + 5, 32'h0, 1'b1, BASE + 5);
    n_chk++; if (dr0 !== 32'hAA22CC44 || err0 !== 1'b0)
      $display("FAIL strobe_zero got dr %h err %b exp aa22cc44 0", dr0, err0); else n_pass++;
  endtask

  task automatic test_bypass();
    step(1'b1, 4'hF, BASE + 7, 32'h12345678, 1'b0, '0);
    step(1'b1, 4'hF, BASE + 7, 32'hFFFFFFFF, 1'b1, BASE + 7);
    n_chk++; if (dr0 !== 32'hFFFFFFFF) $display("FAIL bypass_on got %h exp ffffffff", dr0); else n_pass++;
    n_chk++; if (dr1 !== 32'h12345678) $display("FAIL bypass_off got %h exp 12345678", dr1); else n_pass++;
    step(1'b0, '0, '0, '0, 1'b1, BASE + 7);
    n_chk++; if (dr0 !== 32'hFFFFFFFF || dr1 !== 32'hFFFFFFFF)
      $display("FAIL bypass_after got %h/%h exp ffffffff", dr0, dr1); else n_pass++;
  endtask

  task automatic test_out_of_range();
    step(1'b1, 4'hF, BASE + 0, 32'hCAFEF00D, 1'b0, '0);
    step(1'b1, 4'hF, 32'h0FF, 32'hDEADDEAD, 1'b0, '0);
    n_chk++; if (err0 !== 1'b1 || err1 !== 1'b1) $display("FAIL oor_below_err got %b%b exp 11", err0, err1); else n_pass++;
    idle();
    n_chk++; if (err0 !== 1'b0) $display("FAIL oor_pulse_width got %b exp 0", err0); else n_pass++;
    step(1'b1, 4'hF, BASE + MS, 32'hBEEFBEEF, 1'b0, '0);
    n_chk++; if (err0 !== 1'b1) $display("FAIL oor_above_err got %b exp 1", err0); else n_pass++;
    // The words a truncated index would alias to must be untouched.
    step(1'b0, '0, '0, '0, 1'b1, BASE + MS - 1);
    n_chk++; if (dr0 !== 32'h0 || err0 !== 1'b0) $display("FAIL oor_alias_hi got %h err %b exp 0 0", dr0, err0); else n_pass++;
    step(1'b0, '0, '0, '0, 1'b1, BASE);
    n_chk++; if (dr0 !== 32'hCAFEF00D) $display("FAIL oor_alias_lo got %h exp cafef00d", dr0); else n_pass++;
    step(1'b0, '0, '0, '0, 1'b1, 32'h0FF);
    n_chk++; if (dr0 !== 32'h0 || rv0 !== 1'b1 || err0 !== 1'b1)
      $display("FAIL oor_read got dr %h rv %b err %b exp 0 1 1", dr0, rv0, err0); else n_pass++;
  endtask

  task automatic test_simul_oor();
    int pulses = 0;
    step(1'b1, 4'hF, 32'h300, 32'h1, 1'b1, 32'h050);
    if (err0 === 1'b1) pulses++;
    for (int c = 0; c < 3; c++) begin
      idle();
      if (err0 === 1'b1) pulses++;
    end
    n_chk++; if (pulses != 1) $display("FAIL simul_oor_pulses got %0d exp 1", pulses); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] wa, ra;
    for (int c = 0; c < 600; c++) begin
      wa = ($urandom_range(0, 7) == 0) ? BASE + MS + 32'($urandom_range(0, 3))
                                       : BASE + 32'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? BASE - 32'($urandom_range(1, 4))
                                       : BASE + 32'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, $urandom(),
           1'($urandom_range(0, 1)), ra);
      n_chk++; if (dr0 !== e_dr0 || dr1 !== e_dr1)
        $display("FAIL rand_data cyc %0d got %h/%h exp %h/%h", c, dr0, dr1, e_dr0, e_dr1); else n_pass++;
      n_chk++; if (rv0 !== e_rv || rv1 !== e_rv || err0 !== e_err || err1 !== e_err)
        $display("FAIL rand_flags cyc %0d got rv %b%b err %b%b exp %b %b", c, rv0, rv1, err0, err1, e_rv, e_err); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'hF, BASE + 3, 32'hDEADBEEF, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, BASE + 3);
    n_chk++; if (dr0 !== 32'hDEADBEEF || rv0 !== 1'b1)
      $display("FAIL mid_pre got dr %h rv %b exp deadbeef 1", dr0, rv0); else n_pass++;
    #2;
    nreset = 1'b0;
    #1;
    n_chk++; if (dr0 !== '0 || dr1 !== '0 || rv0 !== 1'b0 || rdy0 !== 1'b0 || err0 !== 1'b0)
      $display("FAIL mid_async got dr %h rv %b rdy %b err %b exp 0", dr0, rv0, rdy0, err0); else n_pass++;
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    for (int c = 1; c <= MS; c++) begin
      step(1'b1, 4'hF, BASE + 3, 32'h55555555, 1'b0, '0);
      n_chk++; if (rdy0 !== e_rdy || rdy1 !== e_rdy)
        $display("FAIL mid_ready cyc %0d got %b%b exp %b", c, rdy0, rdy1, e_rdy); else n_pass++;
    end
    step(1'b0, '0, '0, '0, 1'b1, BASE + 3);
    n_chk++; if (dr0 !== 32'h0 || dr1 !== 32'h0 || rv0 !== 1'b1)
      $display("FAIL mid_word3 got %h/%h rv %b exp 0 1", dr0, dr1, rv0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_bypass();
    test_out_of_range();
    test_simul_oor();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_memory_strb.md
Name: ram_memory_strb

Overview:
Parametrised successor to the single-word RAM block: a word-addressed synchronous RAM with per-byte write strobes, a registered read port with a valid handshake, and read-during-write forwarding. Contents are cleared by a sequencer after reset release, not in a single cycle. An error pulse flags out-of-range accesses. Sits on the core data bus as general-purpose data memory at a configurable base address.

Parameters:
BUS_WIDTH, 32, data/address width in bits; must be a multiple of 8.
ADDR_BASE, 0, first word address decoded by this block.
MEM_SIZE, 256, depth in words; must be >= 2.
READ_BYPASS, 1, 1 = a read hitting the same-cycle write address returns the newly merged data; 0 = it returns the old data.
Derived localparam STRB_WIDTH = BUS_WIDTH/8.

Ports:
clk  input  1  clock, rising edge.
nreset  input  1  asynchronous active-low reset.
write_en  input  1  write request.
write_strb  input  STRB_WIDTH  byte-lane enables; bit i selects data_write[8i+7:8i].
addr_write  input  BUS_WIDTH  absolute word address for the write.
data_write  input  BUS_WIDTH  write data.
read_en  input  1  read request.
addr_read  input  BUS_WIDTH  absolute word address for the read.
data_read  output  BUS_WIDTH  registered read data.
read_valid  output  1  one-cycle pulse: data_read was updated this cycle.
ready  output  1  high when requests are accepted.
error  output  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Decode: idx = addr - ADDR_BASE (unsigned, BUS_WIDTH bits). The address is in range iff idx < MEM_SIZE. Addresses below ADDR_BASE wrap to a large value and are therefore out of range.
- Reset (nreset low, asynchronous): state=CLEAR, clear_idx=0, ready=0, data_read=0, read_valid=0, error=0. The memory array is not cleared by the reset itself.
- FSM states: CLEAR and RUN.
- CLEAR state:
  - Writes 0 to word clear_idx each cycle, then increments clear_idx.
  - After writing word MEM_SIZE-1, moves to RUN.
  - ready is registered and rises on the edge that enters RUN. The full clear takes MEM_SIZE cycles after reset release.
  - read_en and write_en are ignored (no write, no read_valid, no error).
- RUN state: ready=1. Stays in RUN until reset.
- Write (RUN, write_en=1, in range): on the rising edge, each byte lane with write_strb[i]=1 takes the new data; other lanes keep their value. write_strb=0 performs no change and raises no error.
- Read (RUN, read_en=1): registered, latency 1. On the edge after the request, data_read = mem[idx] and read_valid=1 for one cycle.
  - Out-of-range read: data_read=0, read_valid=1.
  - Without read_en, data_read holds its last value and read_valid=0.
- Same-cycle read and write to the same in-range index:
  - READ_BYPASS=1: data_read = stored word merged with the strobed write bytes.
  - READ_BYPASS=0: data_read = the pre-write word.
  - The memory is updated in both cases.
- Error: error=1 for one cycle on the edge after any accepted request (RUN, write_en or read_en) whose address is out of range.
  - An out-of-range write changes no memory.
  - A simultaneous out-of-range read and write gives a single one-cycle error pulse.
- Back-to-back reads and writes are accepted every cycle; there are no stalls in RUN.
- Reset mid-operation: all outputs return to their reset values immediately, and the FSM restarts CLEAR from index 0. Partially written data is discarded by the re-clear.

Test Plan:
- Reset, release, and hold read_en=1 at ADDR_BASE with MEM_SIZE=256 -> ready=0 and read_valid=0 for 256 cycles. ready=1 from cycle 256 on. The first read after that returns 0.
- BUS_WIDTH=32: write 0xAABBCCDD with strb=0xF to word 5, then write 0x11223344 with strb=0x5 to word 5, then read word 5 -> data_read=0xAA22CC44, read_valid high for exactly one cycle.
- Same cycle: write 0xFFFFFFFF (strb 0xF) and read word 7, which holds 0x12345678 -> READ_BYPASS=1 gives 0xFFFFFFFF; READ_BYPASS=0 gives 0x12345678; a following read gives 0xFFFFFFFF in both cases.
- ADDR_BASE=0x100: write at 0x0FF and at 0x100+MEM_SIZE -> error pulses once per access and no memory changes. A read at 0x0FF -> data_read=0, read_valid=1, error=1.
- Simultaneous out-of-range read and write -> exactly one error pulse of width 1.
- Pull nreset low during RUN after writing word 3, then release -> outputs are 0 immediately, ready is low for MEM_SIZE cycles, and word 3 then reads 0.
